dft_multi_bin: RTL
==================

# dft_multi_bin

Streaming multi-bin DFT engine: the next generation of the single-bin DFT block. It accepts one real sample per write and updates NUM_BINS consecutive frequency bins (k_base … k_base+NUM_BINS-1) from one time-multiplexed complex MAC and a shared twiddle ROM. It keeps its own sample counter, adds a ready/overrun handshake, and publishes all bins with a one-cycle done pulse at frame end. It sits between the sample source and the spectral post-processing.

## Interface

- WIDTH, 16: sample, twiddle and output word width (signed)
- N_MAX, 1024: twiddle ROM depth; largest frame length
- LOG_N_MAX, 10: log2(N_MAX)
- FRAC_BITS, 6: fractional bits of the twiddle values; 1.0 = 2^FRAC_BITS
- NUM_BINS, 4: bins computed per frame
- COS_FILE / SIN_FILE, "cos.hex"/"sin.hex": ROM init; entry i = round(cos/sin(2πi/N_MAX)·2^FRAC_BITS)

Ports:

- Clocking: one clock; reset is synchronous and active-high.
- i_sys_clk  in  1  system clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_x  in  WIDTH  signed sample
- i_wr  in  1  sample write strobe
- i_k_base  in  LOG_N_MAX  first bin index; latched on the frame's first sample
- i_logN  in  4  log2(frame length N); latched on the frame's first sample; values >LOG_N_MAX clamp to LOG_N_MAX
- i_clear  in  1  synchronous frame abort
- o_ready  out  1  sample can be accepted this cycle
- o_n  out  LOG_N_MAX  index of the next sample to be accepted
- o_X_re, o_X_im  out  NUM_BINS·WIDTH  bin b in slice b (bin 0 at the lowest slice), signed, saturated
- o_done  out  1  one-cycle pulse when o_X_* update
- o_overrun  out  1  sticky: a write was dropped

## Operation

- Reset: state IDLE, o_ready=1, o_n=0, o_X_*=0, o_done=0, o_overrun=0, accumulators=0.
- Sample acceptance: a sample is accepted on an edge where i_wr=1 and o_ready=1. The block registers x.
  - If o_n=0, it also latches i_k_base and i_logN.
- FSM
  - IDLE → CALC on acceptance.
  - CALC runs NUM_BINS cycles and issues bin b=0..NUM_BINS-1, then → DRAIN.
  - DRAIN runs 2 cycles for the pipeline flush, then → IDLE.
- Bin index: k = (k_base + b) mod N, where N = 2^logN.
- Twiddle address: ((k·n) mod N) << (LOG_N_MAX − logN).
- MAC pipeline per bin:
  - stage 1: ROM read (registered);
  - stage 2: products x·cos and x·sin (2·WIDTH bits, registered), each arithmetic-shifted right by FRAC_BITS (truncation toward −∞);
  - stage 3: acc_re[b] += x·cos, acc_im[b] −= x·sin. Accumulators are WIDTH+LOG_N_MAX bits and never wrap.
- Sample counter: o_n increments when a sample finishes DRAIN.
- Frame end, when that sample has n = N−1:
  - o_X_* take the saturated accumulators (clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1]);
  - accumulators clear, o_n returns to 0, and o_done pulses.
- logN=0 (N=1): every sample is a complete frame and each bin output equals x.
- Overrun: i_wr=1 while o_ready=0 drops the sample and sets o_overrun.
  - Accumulators, the counter and the FSM are unaffected.
  - o_overrun clears only on i_reset or i_clear.
- i_clear:
  - Same effect as reset on the FSM, accumulators, o_n and o_overrun.
  - o_X_* keep the last published frame; o_done=0.
  - It takes priority over a simultaneous i_wr, which is ignored.
- Reset mid-frame (i_reset high in any state): everything returns to reset values on that edge.
- i_k_base and i_logN changes mid-frame are ignored until the next n=0 sample.

## Timing

- Acceptance edge T: o_ready=0 from T+1 through T+NUM_BINS+2, then o_ready=1 at T+NUM_BINS+3.
- Throughput: max one sample per NUM_BINS+3 cycles.
- Bin b accumulates on edge T+b+3; the last bin completes on edge T+NUM_BINS+2.
- Frame-end sample: o_X_* update and o_done=1 in the same cycle as o_ready returns (T+NUM_BINS+3). o_done lasts exactly one cycle.
- A write in the o_ready-returning cycle is accepted (a back-to-back frame is legal).
- o_n updates in the same cycle o_ready returns.

## Test plan

- N=2 (i_logN=1), k_base=0, samples 0, −1 → bins re = [−1, 1, −1, 1], im = [0, 0, 0, 0]. Then samples 0, 1 → re = [1, −1, 1, −1]. o_done pulses exactly twice, each NUM_BINS+3 cycles after the frame's last write.
- N=4, k_base=0, samples 0, 1, 0, 0 → (re, im) per bin = (1, 0), (0, −1), (−1, 0), (0, 1). Then samples 1, 0, 0, 0 → all bins (1, 0).
- Saturation: N=2, samples 32767, 32767 → bin0 re = 32767 (clamped from 65534); bin1 re = 0.
- N=1 (i_logN=0), sample −5 → all bins re = −5, im = 0. o_done after each sample; o_n stays 0.
- Overrun: write at T, second write at T+1 → o_overrun=1, the second sample is dropped, and o_n advances by only 1. i_clear then → o_overrun=0, o_n=0, o_ready=1.
- Reset mid-frame: N=4, after 2 samples, i_reset for 1 cycle (including during CALC) → all outputs at reset values. A fresh 4-sample frame then produces results identical to those from an unreset run.

Source files
------------

// File: rtl/dft_multi_bin_if.sv
// Sample/result bus of the multi-bin DFT engine: sample write side plus published bins.
interface dft_multi_bin_if #(
   parameter int WIDTH     = 16,
   parameter int LOG_N_MAX = 10,
   parameter int NUM_BINS  = 4
);
   logic signed [WIDTH-1:0]          i_x;
   logic                             i_wr;
   logic [LOG_N_MAX-1:0]             i_k_base;
   logic [3:0]                       i_logN;
   logic                             i_clear;
   logic                             o_ready;
   logic [LOG_N_MAX-1:0]             o_n;
   logic [NUM_BINS*WIDTH-1:0]        o_X_re;
   logic [NUM_BINS*WIDTH-1:0]        o_X_im;
   logic                             o_done;
   logic                             o_overrun;

   modport master (
      output i_x, i_wr, i_k_base, i_logN, i_clear,
      input  o_ready, o_n, o_X_re, o_X_im, o_done, o_overrun
   );

   modport slave (
      input  i_x, i_wr, i_k_base, i_logN, i_clear,
      output o_ready, o_n, o_X_re, o_X_im, o_done, o_overrun
   );
endinterface

// File: rtl/dft_multi_bin.sv
// Streaming DFT over NUM_BINS consecutive bins: one sample per write, one time-shared
// complex MAC, shared twiddle ROM, saturated bin results published with a done pulse.
module dft_multi_bin #(
   parameter int WIDTH     = 16,
   parameter int N_MAX     = 1024,
   parameter int LOG_N_MAX = 10,
   parameter int FRAC_BITS = 6,
   parameter int NUM_BINS  = 4
) (
   input  logic              i_sys_clk,
   input  logic              i_reset,
   dft_multi_bin_if.slave    bus
);
   localparam int ACC_W = WIDTH + LOG_N_MAX;
   localparam int PROD_W = 2 * WIDTH;
   localparam int KN_W = 2 * LOG_N_MAX;
   localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
   localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(NUM_BINS - 1);
   localparam logic [3:0] LOGN_CAP = 4'(LOG_N_MAX);

   // Twiddle table is built at elaboration: round(cos/sin(2*pi*i/N_MAX) * 2^FRAC_BITS),
   // from a Q30 quarter-wave Taylor series folded into the four quadrants.
   function automatic logic signed [WIDTH-1:0] twiddle(input int unsigned idx, input bit want_sin);
      longint one;
      longint pi_q30;
      longint x;
      longint c;
      longint s;
      longint term;
      longint v;
      longint half;
      longint r;
      int unsigned q;
      int unsigned j;
      one    = 64'sd1 <<< 30;
      pi_q30 = 64'sd3373259426;
      q      = idx / (N_MAX / 4);
      j      = idx % (N_MAX / 4);
      x      = (pi_q30 * longint'(j)) / longint'(N_MAX / 2);
      term   = one;
      c      = one;
      for (int unsigned k = 1; k <= 10; k++) begin
         term = -(((term * x) / one) * x / one) / longint'((2 * k - 1) * (2 * k));
         c    = c + term;
      end
      term = x;
      s    = x;
      for (int unsigned k = 1; k <= 10; k++) begin
         term = -(((term * x) / one) * x / one) / longint'((2 * k) * (2 * k + 1));
         s    = s + term;
      end
      case (q)
         0:       v = want_sin ? s  : c;
         1:       v = want_sin ? c  : -s;
         2:       v = want_sin ? -s : -c;
         default: v = want_sin ? -c : s;
      endcase
      half = 64'sd1 <<< (30 - FRAC_BITS - 1);
      r = (v >= 0) ? ((v + half) >>> (30 - FRAC_BITS)) : -((-v + half) >>> (30 - FRAC_BITS));
      return WIDTH'(r);
   endfunction

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
      if ((&v[ACC_W-1:WIDTH-1]) || !(|v[ACC_W-1:WIDTH-1])) return v[WIDTH-1:0];
      else if (v[ACC_W-1])                                 return {1'b1, {(WIDTH-1){1'b0}}};
      else                                                 return {1'b0, {(WIDTH-1){1'b1}}};
   endfunction

   typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DRAIN} state_t;

   logic signed [WIDTH-1:0] w_cos_tab [N_MAX];
   logic signed [WIDTH-1:0] w_sin_tab [N_MAX];

   for (genvar i = 0; i < N_MAX; i++) begin : g_rom
      localparam logic signed [WIDTH-1:0] C_COS = twiddle(i, 1'b0);
      localparam logic signed [WIDTH-1:0] C_SIN = twiddle(i, 1'b1);
      assign w_cos_tab[i] = C_COS;
      assign w_sin_tab[i] = C_SIN;
   end

   state_t                   r_state;
   logic [BIN_W-1:0]         r_bin;
   logic                     r_drain;
   logic                     r_ready;
   logic [LOG_N_MAX-1:0]     r_n;
   logic                     r_done;
   logic                     r_overrun;
   logic signed [WIDTH-1:0]  r_x;
   logic [LOG_N_MAX-1:0]     r_kbase;
   logic [3:0]               r_logN;
   logic [3:0]               r_shift;
   logic signed [WIDTH-1:0]  r_X_re [NUM_BINS];
   logic signed [WIDTH-1:0]  r_X_im [NUM_BINS];

   logic                     r_s1_valid;
   logic [BIN_W-1:0]         r_s1_bin;
   logic signed [WIDTH-1:0]  r_cos;
   logic signed [WIDTH-1:0]  r_sin;
   logic                     r_s2_valid;
   logic [BIN_W-1:0]         r_s2_bin;
   logic signed [PROD_W-1:0] r_p_re;
   logic signed [PROD_W-1:0] r_p_im;
   logic signed [ACC_W-1:0]  r_acc_re [NUM_BINS];
   logic signed [ACC_W-1:0]  r_acc_im [NUM_BINS];

   logic [3:0]               w_logN_clamp;
   logic [LOG_N_MAX-1:0]     w_k;
   logic [KN_W-1:0]          w_kn;
   logic [LOG_N_MAX-1:0]     w_addr;
   logic [LOG_N_MAX-1:0]     w_nmask;
   logic                     w_last_n;
   logic                     w_frame_end;
   logic signed [ACC_W-1:0]  w_acc_re_nxt [NUM_BINS];
   logic signed [ACC_W-1:0]  w_acc_im_nxt [NUM_BINS];

   assign w_logN_clamp = (bus.i_logN > LOGN_CAP) ? LOGN_CAP : bus.i_logN;
   // (k mod N)*n mod N scaled by N_MAX/N equals the low LOG_N_MAX bits of (k*n) << shift.
   assign w_k         = r_kbase + LOG_N_MAX'(r_bin);
   assign w_kn        = KN_W'(w_k) * KN_W'(r_n);
   assign w_addr      = LOG_N_MAX'(w_kn << r_shift);
   assign w_nmask     = ~({LOG_N_MAX{1'b1}} << r_logN);
   assign w_last_n    = (r_n == w_nmask);
   assign w_frame_end = (r_state == ST_DRAIN) && r_drain && w_last_n;

   // The last bin lands on the frame-end edge, so publication sees its update through this bypass.
   always_comb begin
      for (int unsigned b = 0; b < NUM_BINS; b++) begin
         w_acc_re_nxt[b] = r_acc_re[b];
         w_acc_im_nxt[b] = r_acc_im[b];
         if (r_s2_valid && (r_s2_bin == BIN_W'(b))) begin
            w_acc_re_nxt[b] = r_acc_re[b] + ACC_W'(r_p_re >>> FRAC_BITS);
            w_acc_im_nxt[b] = r_acc_im[b] - ACC_W'(r_p_im >>> FRAC_BITS);
         end
      end
   end

   always_ff @(posedge i_sys_clk) begin
      r_done <= 1'b0;
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_bin     <= '0;
         r_drain   <= 1'b0;
         r_ready   <= 1'b1;
         r_n       <= '0;
         r_overrun <= 1'b0;
         r_x       <= '0;
         r_kbase   <= '0;
         r_logN    <= '0;
         r_shift   <= LOGN_CAP;
         for (int unsigned b = 0; b < NUM_BINS; b++) begin
            r_X_re[b] <= '0;
            r_X_im[b] <= '0;
         end
      end else if (bus.i_clear) begin
         r_state   <= ST_IDLE;
         r_bin     <= '0;
         r_drain   <= 1'b0;
         r_ready   <= 1'b1;
         r_n       <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (bus.i_wr && !r_ready) r_overrun <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (bus.i_wr) begin
                  r_x     <= bus.i_x;
                  r_ready <= 1'b0;
                  r_bin   <= '0;
                  r_state <= ST_CALC;
                  if (r_n == '0) begin
                     r_kbase <= bus.i_k_base;
                     r_logN  <= w_logN_clamp;
                     r_shift <= LOGN_CAP - w_logN_clamp;
                  end
               end
            end
            ST_CALC: begin
               if (r_bin == BIN_LAST) begin
                  r_state <= ST_DRAIN;
                  r_drain <= 1'b0;
               end else begin
                  r_bin <= r_bin + BIN_W'(1);
               end
            end
            ST_DRAIN: begin
               if (r_drain) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
                  r_drain <= 1'b0;
                  if (w_last_n) begin
                     r_n    <= '0;
                     r_done <= 1'b1;
                     for (int unsigned b = 0; b < NUM_BINS; b++) begin
                        r_X_re[b] <= sat(w_acc_re_nxt[b]);
                        r_X_im[b] <= sat(w_acc_im_nxt[b]);
                     end
                  end else begin
                     r_n <= r_n + LOG_N_MAX'(1);
                  end
               end else begin
                  r_drain <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_reset || bus.i_clear) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         for (int unsigned b = 0; b < NUM_BINS; b++) begin
            r_acc_re[b] <= '0;
            r_acc_im[b] <= '0;
         end
      end else begin
         r_s1_valid <= (r_state == ST_CALC);
         r_s1_bin   <= r_bin;
         r_cos      <= w_cos_tab[w_addr];
         r_sin      <= w_sin_tab[w_addr];
         r_s2_valid <= r_s1_valid;
         r_s2_bin   <= r_s1_bin;
         r_p_re     <= r_x * r_cos;
         r_p_im     <= r_x * r_sin;
         for (int unsigned b = 0; b < NUM_BINS; b++) begin
            r_acc_re[b] <= w_frame_end ? '0 : w_acc_re_nxt[b];
            r_acc_im[b] <= w_frame_end ? '0 : w_acc_im_nxt[b];
         end
      end
   end

   for (genvar b = 0; b < NUM_BINS; b++) begin : g_out
      assign bus.o_X_re[b*WIDTH +: WIDTH] = r_X_re[b];
      assign bus.o_X_im[b*WIDTH +: WIDTH] = r_X_im[b];
   end

   assign bus.o_ready   = r_ready;
   assign bus.o_n       = r_n;
   assign bus.o_done    = r_done;
   assign bus.o_overrun = r_overrun;
endmodule
